// File: rtl/uart_pkg.sv
// Shared UART definitions: default geometry, frame-sequencer state encoding
// and the command byte constants used by the framing protocol.
package uart_pkg;

  localparam int unsigned MAX_BITS_DEF   = 8;
  localparam int unsigned PARAMETERS_DEF = 6;
  localparam int unsigned FRAME_W_DEF    = MAX_BITS_DEF * PARAMETERS_DEF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    GAP   = 3'd4
  } uart_state_e;

  localparam logic [7:0] CMD_ENCODE = 8'h01;
  localparam logic [7:0] CMD_DECODE = 8'h02;
  localparam logic [7:0] FRAME_END  = 8'h0F;

endpackage

// File: rtl/uart_byte_tx.sv
// Single-character serializer: start bit, MAX_BITS data bits LSB first,
// STOP_BITS stop bits, one bit per clk_N cycle.
// Ports: clk_N/rst_i (async, active-high); start_i + data_i load a character
// when ready_o is high; tx_o is the registered line; ready_o rises on the
// edge that launches the final stop bit so a new character can follow
// without an idle cycle.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned MAX_BITS  = MAX_BITS_DEF,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                clk_N,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [MAX_BITS-1:0] data_i,
  output logic                tx_o,
  output logic                ready_o
);

  localparam int unsigned CHAR_BITS = 1 + MAX_BITS + STOP_BITS;
  localparam int unsigned CW        = $clog2(CHAR_BITS);

  logic [CW-1:0]       cnt_q;
  logic [MAX_BITS-1:0] shreg_q;

  // cnt_q is the position of the bit launched on the next edge
  always_ff @(posedge clk_N or posedge rst_i) begin
    if (rst_i) begin
      tx_o    <= 1'b1;
      ready_o <= 1'b1;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (ready_o) begin
      if (start_i) begin
        tx_o    <= 1'b0;
        shreg_q <= data_i;
        cnt_q   <= CW'(1);
        ready_o <= 1'b0;
      end
    end else begin
      if (cnt_q <= CW'(MAX_BITS)) begin
        tx_o    <= shreg_q[0];
        shreg_q <= shreg_q >> 1;
      end else begin
        tx_o <= 1'b1;
      end
      if (cnt_q == CW'(CHAR_BITS - 1)) begin
        ready_o <= 1'b1;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Multi-byte UART frame transmitter: sends len_i bytes of frame_i, most
// significant byte first, with optional idle gaps between bytes.
// Ports: clk_N bit clock; rst_i async active-high; frame_i/len_i captured on
// accept (tx_valid_i & tx_ready_o); UART_TX serial line (idle high);
// tx_ready_o idle; busy_o = !tx_ready_o; tx_done_o one-cycle completion pulse.
// The FSM re-enters IDLE on the edge that launches the final stop bit, so a
// request taken in the tx_done_o cycle starts right after that stop bit.
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int unsigned MAX_BITS   = MAX_BITS_DEF,
  parameter int unsigned PARAMETERS = PARAMETERS_DEF,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned GAP_BITS   = 0
) (
  input  logic                           clk_N,
  input  logic                           rst_i,
  input  logic [MAX_BITS*PARAMETERS-1:0] frame_i,
  input  logic [2:0]                     len_i,
  input  logic                           tx_valid_i,
  output logic                           tx_ready_o,
  output logic                           UART_TX,
  output logic                           busy_o,
  output logic                           tx_done_o
);

  localparam int unsigned FRAME_W  = MAX_BITS * PARAMETERS;
  localparam int unsigned MAX_SG   = (STOP_BITS > GAP_BITS) ? STOP_BITS : GAP_BITS;
  localparam int unsigned CNT_MAX  = (MAX_BITS > MAX_SG) ? MAX_BITS : MAX_SG;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W    = $clog2(PARAMETERS + 1);
  localparam int unsigned STOP_END = STOP_BITS - 1;
  // last byte leaves STOP one cycle early: IDLE covers its final stop bit
  localparam int unsigned STOP_END_LAST = (STOP_BITS > 1) ? STOP_BITS - 2 : 0;
  localparam int unsigned GAP_END  = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     len_q, len_eff_c;
  logic [FRAME_W-1:0]   frame_q, src_c, shifted_c;
  logic [MAX_BITS-1:0]  byte_c;
  logic                 accept_c, last_c, start_req_c, byte_start_c, byte_ready;

  assign accept_c  = tx_valid_i && tx_ready_o;
  assign last_c    = (idx_q == len_q - IDX_W'(1));
  assign len_eff_c = (len_i == '0 || 32'(len_i) > PARAMETERS) ? IDX_W'(PARAMETERS)
                                                               : IDX_W'(len_i);

  // Byte 0 comes straight from frame_i on the accept edge
  assign src_c     = (state_q == IDLE) ? frame_i : frame_q;
  assign shifted_c = src_c << (32'(idx_d) * MAX_BITS);
  assign byte_c    = shifted_c[FRAME_W-1 -: MAX_BITS];
  assign byte_start_c = start_req_c && byte_ready;

  // Next-state logic: state reflects the kind of bit launched on each edge
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    start_req_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d     = START;
          cnt_d       = '0;
          idx_d       = '0;
          start_req_c = 1'b1;
        end
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        if (cnt_q == CNT_W'(MAX_BITS - 1)) begin
          cnt_d = '0;
          if (last_c && STOP_BITS == 1) state_d = IDLE;
          else                          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == (last_c ? CNT_W'(STOP_END_LAST) : CNT_W'(STOP_END))) begin
          cnt_d = '0;
          if (last_c) begin
            state_d = IDLE;
          end else if (GAP_BITS > 0) begin
            state_d = GAP;
          end else begin
            state_d     = START;
            idx_d       = idx_q + IDX_W'(1);
            start_req_c = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(GAP_END)) begin
          state_d     = START;
          cnt_d       = '0;
          idx_d       = idx_q + IDX_W'(1);
          start_req_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters, captured request and registered status outputs
  always_ff @(posedge clk_N or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      len_q      <= '0;
      frame_q    <= '0;
      tx_ready_o <= 1'b1;
      busy_o     <= 1'b0;
      tx_done_o  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      if (accept_c) begin
        len_q   <= len_eff_c;
        frame_q <= frame_i;
      end
      tx_ready_o <= (state_d == IDLE);
      busy_o     <= (state_d != IDLE);
      tx_done_o  <= (state_d == IDLE) && (state_q != IDLE);
    end
  end

  uart_byte_tx #(
    .MAX_BITS  (MAX_BITS),
    .STOP_BITS (STOP_BITS)
  ) u_byte_tx (
    .clk_N   (clk_N),
    .rst_i   (rst_i),
    .start_i (byte_start_c),
    .data_i  (byte_c),
    .tx_o    (UART_TX),
    .ready_o (byte_ready)
  );

endmodule

// File: doc/uart_frame_tx.md
UART_FRAME_TX -- requirements
Module: uart_frame_tx

Interface
REQ-001 SHALL have parameter MAX_BITS, default 8: data bits per character.
REQ-002 SHALL have parameter PARAMETERS, default 6: maximum bytes per frame.
REQ-003 SHALL have parameter STOP_BITS, default 1, legal range 1..2: stop bits per character.
REQ-004 SHALL have parameter GAP_BITS, default 0: idle-high bit periods inserted between bytes, never after the last byte.
REQ-005 SHALL have port clk_N  input  1: bit clock, one UART bit period per cycle.
REQ-006 SHALL have port rst_i  input  1: reset, asynchronous, active-high.
REQ-007 SHALL have port frame_i  input  MAX_BITS*PARAMETERS: frame; byte 0 is the top byte [47:40], byte 5 is the bottom byte [7:0].
REQ-008 SHALL have port len_i  input  3: number of bytes to send.
REQ-009 SHALL have port tx_valid_i  input  1: frame request.
REQ-010 SHALL have port tx_ready_o  output  1: block idle; a request is accepted when tx_valid_i is also high.
REQ-011 SHALL have port UART_TX  output  1: serial line, idle high.
REQ-012 SHALL have port busy_o  output  1: frame in progress.
REQ-013 SHALL have port tx_done_o  output  1: one-cycle pulse at frame completion.

Function
REQ-014 SHALL accept a frame on the clk_N edge where tx_valid_i=1 and tx_ready_o=1, and register frame_i and len_i on that edge only.
- Changes to frame_i or len_i after acceptance SHALL be ignored.
REQ-015 SHALL clamp len_i: values 0 or greater than PARAMETERS are treated as PARAMETERS.
REQ-016 SHALL send bytes in order byte 0, byte 1, and so on (most-significant byte of frame_i first).
REQ-017 SHALL send each byte as: one start bit (0), then MAX_BITS data bits LSB first, then STOP_BITS stop bits (1).
REQ-018 SHALL register UART_TX, with each bit held for exactly one clk_N cycle.
- The start bit of byte 0 SHALL appear in the cycle immediately after the accept edge.
REQ-019 SHALL implement an FSM with states IDLE, START, DATA, STOP, GAP and transitions:
- IDLE->START on accept.
- START->DATA after 1 cycle.
- DATA->STOP after MAX_BITS cycles.
- STOP->GAP after STOP_BITS cycles if bytes remain and GAP_BITS>0.
- STOP->START if bytes remain and GAP_BITS=0.
- STOP->IDLE if no bytes remain.
- GAP->START after GAP_BITS cycles.
REQ-020 SHALL take exactly len*(1+MAX_BITS+STOP_BITS) + (len-1)*GAP_BITS cycles from the accept edge until tx_ready_o returns high.
REQ-021 SHALL assert tx_ready_o only in IDLE, and SHALL assert busy_o equal to NOT tx_ready_o.
REQ-022 SHALL pulse tx_done_o for the single cycle in which the FSM first re-enters IDLE.
REQ-023 SHALL accept a request presented in the tx_done_o cycle; the next start bit then directly follows the last stop bit.
REQ-024 SHALL ignore tx_valid_i while busy, with no queuing and no effect on the current frame.
REQ-025 SHALL size the bit and byte counters so that MAX_BITS, STOP_BITS, GAP_BITS and PARAMETERS limits never wrap.

Reset
REQ-026 SHALL, while rst_i is high, asynchronously force:
- FSM=IDLE and counters=0.
- UART_TX=1, tx_ready_o=1, busy_o=0, tx_done_o=0.
REQ-027 SHALL, on reset during a frame, abort the frame immediately (line high), send no further bits, and emit no tx_done_o pulse.
REQ-028 SHALL accept a request on the first clk_N edge after rst_i deasserts.

Structure
REQ-029 SHALL place the following in shared package uart_pkg:
- MAX_BITS and PARAMETERS defaults, and the frame width.
- The FSM state enum.
- Command constants CMD_ENCODE=8'h01, CMD_DECODE=8'h02, FRAME_END=8'h0F.
REQ-030 SHALL use one sub-module, uart_byte_tx, which serializes one character (start/data/stop) with its own start/done handshake; uart_frame_tx sequences bytes and gaps around it.

Verification
REQ-031 Default parameters, frame 48'h01_A5_3C_00_00_0F, len 6 -> 60 line cycles; byte 0 line sequence 0,1,0,0,0,0,0,0,0,1; tx_done_o pulses at cycle 60; loopback through the team's UART receiver yields the same 48 bits.
REQ-032 len 2, frame 48'h02_FF_xx.. -> 20 cycles carrying 0x02 then 0xFF; len 0 and len 7 -> 60 cycles each.
REQ-033 GAP_BITS=2, STOP_BITS=2, len 3 -> 3*11+2*2=37 cycles; line high during both stop bits and both gaps.
REQ-034 tx_valid_i held high continuously with alternating frames -> second start bit in the cycle after the first frame's last stop bit; no idle cycle between frames.
REQ-035 rst_i pulsed during byte 2 data bits -> UART_TX=1 within the reset cycle, no tx_done_o pulse, new frame accepted on the first edge after release.
REQ-036 frame_i changed and tx_valid_i toggled mid-frame -> transmitted bits match the frame captured at accept; no extra accept occurs.
